ps2_command_sequencer: RTL and testbench
========================================

Name: ps2_command_sequencer

Overview:
- Sequences decoded PS/2 set-2 scan codes into operator commands that configure the control system registers `temperatura`, `ignicion` and `presencia`.
- Sits between the PS/2 byte receiver (`rx_done_tick`, 8-bit byte) and the downstream control logic.
- Strips break and extended codes, parses multi-key commands, validates them, and commits atomically on Enter with a one-cycle `datos_listos` strobe.
- An unfinished command is abandoned after a timeout.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed mid-command before abort (1 s at 50 MHz); counter width is clog2(TIMEOUT_CYCLES).
- TEMP_RST, 5'd25, reset value of `temperatura`.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset (0 = reset, sampled on clk).
- rx_done_tick  input  1  one-cycle strobe: `dato_rx` holds a new received byte.
- dato_rx  input  8  received scan-code byte.
- temperatura  output  5  committed temperature setpoint, 0..31.
- ignicion  output  1  committed ignition flag.
- presencia  output  1  committed presence flag.
- datos_listos  output  1  one-cycle pulse on every successful commit.
- error  output  1  one-cycle pulse on a rejected command or timeout.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all prefix flags and the timer clear.
  - temperatura=TEMP_RST, ignicion=0, presencia=0, datos_listos=0, error=0, busy=0.
  - Reset mid-command discards the partial command; no pulse is emitted.
- Byte filter, applied before the FSM:
  - F0 sets skip_next; the following byte is discarded whatever its value.
  - E0 sets ext. On the next byte: if it is F0, set skip_next and clear ext; otherwise discard it and clear ext.
  - Discarded and prefix bytes do not advance the FSM but do reload the timer.
  - Only bytes that survive the filter ("make codes") reach the FSM.
- Key map:
  - T=2C, I=43, P=4D, Enter=5A, Esc=76.
  - Digits 0..9 = 45,16,1E,26,25,2E,36,3D,3E,46.
- FSM states: IDLE, GET_D1, GET_D2, GET_BIT, WAIT_ENTER.
  - IDLE: T -> GET_D1 with cmd=TEMP. I -> GET_BIT with cmd=IGN. P -> GET_BIT with cmd=PRES. Any other make code is ignored (no error).
  - GET_D1: digit d -> acc=d, go to GET_D2.
  - GET_D2:
    - Digit d -> acc=acc*10+d, go to WAIT_ENTER.
    - Enter -> commit acc.
  - GET_BIT: digit 0 or 1 -> store bit, go to WAIT_ENTER.
  - WAIT_ENTER: Enter -> commit.
  - Esc in any non-IDLE state -> IDLE with no commit and no error.
  - Any other make code in a non-IDLE state -> IDLE with error pulse. This includes digits 2..9 in GET_BIT and Enter in GET_D1.
- Arithmetic: acc is 7 bits wide (max 99).
- Commit (cmd=TEMP):
  - acc ≤ 31: temperatura=acc[4:0] and datos_listos pulses.
  - acc > 31: error pulse; temperatura is unchanged.
- Commit (cmd=IGN/PRES): the stored bit is written to the selected flag only; datos_listos pulses.
- Latency: the output register update and the datos_listos/error pulse occur on the clk edge after the edge sampling rx_done_tick with the deciding byte (1 cycle). After a commit or error the FSM returns to IDLE on the same edge.
- Timeout:
  - The timer counts while state≠IDLE and rx_done_tick=0.
  - Any rx_done_tick reloads it to 0.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, error pulse, clear prefix flags.
  - If rx_done_tick and expiry coincide, the byte wins: it is processed and the timer cleared.
- `busy` is registered and equals (state≠IDLE).
- datos_listos and error are never high in the same cycle.

Test Plan:
- Bytes 2C,F0,2C,1E,F0,1E,45,F0,45,5A,F0,5A ("T20 Enter" with breaks) -> temperatura=20 and a single datos_listos pulse one cycle after the 5A byte; ignicion and presencia unchanged.
- 43,16,5A then 4D,16,5A then 43,45,5A -> ignicion=1, then presencia=1, then ignicion=0; three datos_listos pulses; error never asserted.
- 2C,1E,3E,5A ("T28") -> temperatura=28. Then 2C,26,1E,5A ("T32") -> error pulse; temperatura stays 28.
- 2C,76 (Esc) -> busy drops, no pulses. 43,1E ("I2") -> error pulse, state IDLE. E0,75,E0,F0,75 in IDLE -> ignored; busy stays 0.
- With TIMEOUT_CYCLES=100: send 2C,16, then idle -> error pulse exactly 100 cycles after the last tick, busy=0. Repeat with a byte arriving on the expiry cycle -> no timeout.
- Drive rst=0 for one cycle after 2C,1E -> all outputs at reset values (temperatura=25). A following 5A produces no pulse.

Source files
------------

// File: rtl/ps2_command_sequencer.sv
// PS/2 set-2 command sequencer: strips break/extended codes, parses T/I/P
// commands and commits them atomically on Enter.
module ps2_command_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [4:0]  TEMP_RST       = 5'd25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] dato_rx,
    output logic [4:0] temperatura,
    output logic       ignicion,
    output logic       presencia,
    output logic       datos_listos,
    output logic       error,
    output logic       busy
);

    localparam int TW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] K_T   = 8'h2C;
    localparam logic [7:0] K_I   = 8'h43;
    localparam logic [7:0] K_P   = 8'h4D;
    localparam logic [7:0] K_ENT = 8'h5A;
    localparam logic [7:0] K_ESC = 8'h76;
    localparam logic [7:0] K_BRK = 8'hF0;
    localparam logic [7:0] K_EXT = 8'hE0;

    typedef enum logic [2:0] {
        IDLE, GET_D1, GET_D2, GET_BIT, WAIT_ENTER
    } state_t;

    typedef enum logic [1:0] {
        CMD_TEMP, CMD_IGN, CMD_PRES
    } cmd_t;

    state_t        state;
    cmd_t          cmd;
    logic [6:0]    acc;
    logic          bitv;
    logic          skip_next;
    logic          ext;
    logic [TW-1:0] timer;

    logic       is_dig;
    logic [3:0] dig_val;
    logic       make;
    logic       idle_st;
    logic       is_ent;
    logic       is_esc;
    logic       expired;
    logic [6:0] acc_next;

    always_comb begin
        is_dig  = 1'b1;
        dig_val = 4'd0;
        unique case (dato_rx)
            8'h45:   dig_val = 4'd0;
            8'h16:   dig_val = 4'd1;
            8'h1E:   dig_val = 4'd2;
            8'h26:   dig_val = 4'd3;
            8'h25:   dig_val = 4'd4;
            8'h2E:   dig_val = 4'd5;
            8'h36:   dig_val = 4'd6;
            8'h3D:   dig_val = 4'd7;
            8'h3E:   dig_val = 4'd8;
            8'h46:   dig_val = 4'd9;
            default: is_dig  = 1'b0;
        endcase
    end

    // Only bytes that pass the prefix filter are make codes.
    assign make = rx_done_tick && !skip_next && !ext
               && (dato_rx != K_BRK) && (dato_rx != K_EXT);

    assign idle_st  = (state == IDLE);
    assign is_ent   = (dato_rx == K_ENT);
    assign is_esc   = (dato_rx == K_ESC);
    assign expired  = !idle_st && !rx_done_tick && (timer == T_LAST);
    assign acc_next = acc * 7'd10 + 7'(dig_val);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cmd          <= CMD_TEMP;
            acc          <= '0;
            bitv         <= 1'b0;
            skip_next    <= 1'b0;
            ext          <= 1'b0;
            timer        <= '0;
            temperatura  <= TEMP_RST;
            ignicion     <= 1'b0;
            presencia    <= 1'b0;
            datos_listos <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            datos_listos <= 1'b0;
            error        <= 1'b0;

            if (rx_done_tick) begin
                timer <= '0;
                if (skip_next) begin
                    skip_next <= 1'b0;
                end else if (ext) begin
                    ext       <= 1'b0;
                    skip_next <= (dato_rx == K_BRK);
                end else if (dato_rx == K_BRK) begin
                    skip_next <= 1'b1;
                end else if (dato_rx == K_EXT) begin
                    ext <= 1'b1;
                end
            end else if (expired) begin
                state     <= IDLE;
                busy      <= 1'b0;
                error     <= 1'b1;
                skip_next <= 1'b0;
                ext       <= 1'b0;
                timer     <= '0;
            end else if (!idle_st) begin
                timer <= timer + 1'b1;
            end

            if (make) begin
                unique case (1'b1)
                    idle_st: begin
                        unique case (dato_rx)
                            K_T: begin
                                state <= GET_D1;
                                cmd   <= CMD_TEMP;
                                busy  <= 1'b1;
                            end
                            K_I: begin
                                state <= GET_BIT;
                                cmd   <= CMD_IGN;
                                busy  <= 1'b1;
                            end
                            K_P: begin
                                state <= GET_BIT;
                                cmd   <= CMD_PRES;
                                busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    (!idle_st && is_esc): begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    (is_ent && (state == GET_D2
                             || state == WAIT_ENTER)): begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        unique case (cmd)
                            CMD_TEMP: begin
                                if (acc <= 7'd31) begin
                                    temperatura  <= acc[4:0];
                                    datos_listos <= 1'b1;
                                end else begin
                                    error <= 1'b1;
                                end
                            end
                            CMD_IGN: begin
                                ignicion     <= bitv;
                                datos_listos <= 1'b1;
                            end
                            default: begin
                                presencia    <= bitv;
                                datos_listos <= 1'b1;
                            end
                        endcase
                    end
                    (is_dig && state == GET_D1): begin
                        acc   <= 7'(dig_val);
                        state <= GET_D2;
                    end
                    (is_dig && state == GET_D2): begin
                        acc   <= acc_next;
                        state <= WAIT_ENTER;
                    end
                    (is_dig && dig_val < 4'd2
                            && state == GET_BIT): begin
                        bitv  <= dig_val[0];
                        state <= WAIT_ENTER;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Scoreboard bench for ps2_command_sequencer: a key-level reference model
// predicts every commit/error pulse, a negedge monitor checks them.
module tb_ps2_command_sequencer;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] dato_rx = 8'h00;
    logic [4:0] temperatura;
    logic       ignicion;
    logic       presencia;
    logic       datos_listos;
    logic       error;
    logic       busy;

    ps2_command_sequencer #(
        .TIMEOUT_CYCLES(T),
        .TEMP_RST(5'd25)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_done_tick(rx_done_tick),
        .dato_rx(dato_rx),
        .temperatura(temperatura),
        .ignicion(ignicion),
        .presencia(presencia),
        .datos_listos(datos_listos),
        .error(error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit ok;
        int at;
        int temp;
        bit ign;
        bit pres;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pend[$];
    int         m_temp = 25;
    bit         m_ign  = 1'b0;
    bit         m_pres = 1'b0;
    bit         m_skip = 1'b0;
    bit         m_ext  = 1'b0;
    int         cmps   = 0;
    int         errs   = 0;

    task automatic chk(input string name, input int act, input int exp);
        cmps++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int dig(input logic [7:0] b);
        case (b)
            8'h45: return 0;
            8'h16: return 1;
            8'h1E: return 2;
            8'h26: return 3;
            8'h25: return 4;
            8'h2E: return 5;
            8'h36: return 6;
            8'h3D: return 7;
            8'h3E: return 8;
            8'h46: return 9;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] key_of(input int d);
        case (d)
            0: return 8'h45;
            1: return 8'h16;
            2: return 8'h1E;
            3: return 8'h26;
            4: return 8'h25;
            5: return 8'h2E;
            6: return 8'h36;
            7: return 8'h3D;
            8: return 8'h3E;
            default: return 8'h46;
        endcase
    endfunction

    task automatic push_ev(input bit ok, input int at);
        ev_t e;
        e.ok = ok; e.at = at; e.temp = m_temp;
        e.ign = m_ign; e.pres = m_pres;
        exp_q.push_back(e);
    endtask

    // Interprets the make codes of the pending command as a whole.
    task automatic model_key(input logic [7:0] b, input int at);
        int n;
        int d;
        int v;
        logic [7:0] head;
        if (pend.size() == 0) begin
            if (b == 8'h2C || b == 8'h43 || b == 8'h4D) pend.push_back(b);
            return;
        end
        if (b == 8'h76) begin
            pend.delete();
            return;
        end
        n = pend.size();
        d = dig(b);
        head = pend[0];
        if (head == 8'h2C) begin
            if (n <= 2 && d >= 0) begin
                pend.push_back(b);
                return;
            end
            if (n >= 2 && b == 8'h5A) begin
                v = (n == 2) ? dig(pend[1])
                             : dig(pend[1]) * 10 + dig(pend[2]);
                if (v <= 31) m_temp = v;
                push_ev(v <= 31, at);
                pend.delete();
                return;
            end
        end else begin
            if (n == 1 && (d == 0 || d == 1)) begin
                pend.push_back(b);
                return;
            end
            if (n == 2 && b == 8'h5A) begin
                if (head == 8'h43) m_ign = bit'(dig(pend[1]));
                else m_pres = bit'(dig(pend[1]));
                push_ev(1'b1, at);
                pend.delete();
                return;
            end
        end
        push_ev(1'b0, at);
        pend.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input int at);
        if (m_skip) begin
            m_skip = 1'b0;
        end else if (m_ext) begin
            m_ext  = 1'b0;
            m_skip = (b == 8'hF0);
        end else if (b == 8'hF0) begin
            m_skip = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            model_key(b, at);
        end
    endtask

    // Called at a negedge; the byte is sampled on the next posedge.
    task automatic send(input logic [7:0] b, input int gap);
        int at;
        at = cyc + 1;
        rx_done_tick = 1'b1;
        dato_rx = b;
        model_byte(b, at);
        @(negedge clk);
        rx_done_tick = 1'b0;
        chk("busy", int'(busy), int'(pend.size() != 0));
        chk("temperatura", int'(temperatura), m_temp);
        chk("ignicion", int'(ignicion), int'(m_ign));
        chk("presencia", int'(presencia), int'(m_pres));
        if (pend.size() != 0 && gap >= T) begin
            push_ev(1'b0, at + T - 1 + 1);
            pend.delete();
            m_skip = 1'b0;
            m_ext  = 1'b0;
        end
        repeat (gap) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst && (datos_listos || error)) begin
            chk("pulse_exclusive", int'(datos_listos && error), 0);
            if (exp_q.size() == 0) begin
                cmps++;
                errs++;
                $display("FAIL unexpected_pulse: dl=%0b err=%0b cycle %0d",
                         datos_listos, error, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_dl", int'(datos_listos), int'(e.ok));
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_temp", int'(temperatura), e.temp);
                chk("pulse_ign", int'(ignicion), int'(e.ign));
                chk("pulse_pres", int'(presencia), int'(e.pres));
            end
        end
    end

    function automatic int rgap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 4) return T - 1;
        if (r < 7) return T + $urandom_range(0, 3);
        return $urandom_range(0, 3);
    endfunction

    task automatic rand_cmd();
        logic [7:0] keys[$];
        logic [7:0] pool[17];
        int r;
        pool = '{8'h2C, 8'h43, 8'h4D, 8'h5A, 8'h76, 8'h45, 8'h16,
                 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                 8'h46, 8'h1C, 8'h29};
        r = $urandom_range(0, 9);
        if (r < 4) begin
            keys.push_back(8'h2C);
            if ($urandom_range(0, 2) == 0) begin
                keys.push_back(key_of($urandom_range(0, 9)));
            end else begin
                keys.push_back(key_of($urandom_range(0, 4)));
                keys.push_back(key_of($urandom_range(0, 9)));
            end
        end else if (r < 8) begin
            keys.push_back(r < 6 ? 8'h43 : 8'h4D);
            keys.push_back(key_of($urandom_range(0, 5) < 5
                                  ? $urandom_range(0, 1)
                                  : $urandom_range(2, 9)));
        end else if (r == 8) begin
            keys.push_back(pool[$urandom_range(0, 16)]);
        end else begin
            keys.push_back(8'h2C);
            keys.push_back(8'h76);
        end
        if (r != 9) keys.push_back(8'h5A);
        if ($urandom_range(0, 9) == 0) begin
            keys[$urandom_range(0, keys.size() - 1)] =
                pool[$urandom_range(0, 16)];
        end
        foreach (keys[i]) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                send(8'hE0, rgap());
                send(pool[$urandom_range(0, 16)], rgap());
            end else if (r == 1) begin
                send(8'hE0, rgap());
                send(8'hF0, rgap());
                send(pool[$urandom_range(0, 16)], rgap());
            end
            send(keys[i], rgap());
            if ($urandom_range(0, 1) == 1) begin
                send(8'hF0, rgap());
                send(keys[i], rgap());
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        pend.delete();
        m_skip = 1'b0;
        m_ext  = 1'b0;
        m_temp = 25;
        m_ign  = 1'b0;
        m_pres = 1'b0;
        chk("rst_temp", int'(temperatura), 25);
        chk("rst_ign", int'(ignicion), 0);
        chk("rst_pres", int'(presencia), 0);
        chk("rst_dl", int'(datos_listos), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_busy", int'(busy), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        @(negedge clk);

        // "T20 Enter" with break codes
        send(8'h2C, 1); send(8'hF0, 1); send(8'h2C, 1);
        send(8'h1E, 1); send(8'hF0, 1); send(8'h1E, 1);
        send(8'h45, 1); send(8'hF0, 1); send(8'h45, 1);
        send(8'h5A, 1); send(8'hF0, 1); send(8'h5A, 1);
        chk("t20", int'(temperatura), 20);

        send(8'h43, 0); send(8'h16, 0); send(8'h5A, 1);
        send(8'h4D, 0); send(8'h16, 0); send(8'h5A, 1);
        send(8'h43, 0); send(8'h45, 0); send(8'h5A, 1);
        chk("ign0", int'(ignicion), 0);
        chk("pres1", int'(presencia), 1);

        send(8'h2C, 0); send(8'h1E, 0); send(8'h3E, 0); send(8'h5A, 1);
        send(8'h2C, 0); send(8'h26, 0); send(8'h1E, 0); send(8'h5A, 1);
        chk("t28_kept", int'(temperatura), 28);

        send(8'h2C, 0); send(8'h76, 1);
        send(8'h43, 0); send(8'h1E, 1);
        send(8'hE0, 0); send(8'h75, 0);
        send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 2);
        chk("ext_idle_busy", int'(busy), 0);

        // timeout, then a byte landing on the expiry cycle
        send(8'h2C, 0); send(8'h16, T);
        chk("timeout_busy", int'(busy), 0);
        send(8'h2C, 0); send(8'h16, T - 1); send(8'h5A, 1);
        chk("late_byte_temp", int'(temperatura), 1);

        send(8'h2C, 0); send(8'h1E, 0);
        do_reset();
        send(8'h5A, 3);

        repeat (150) rand_cmd();
        send(8'h76, 0);
        send(8'h76, 0);
        repeat (T + 5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmps, errs);
        $finish;
    end

endmodule
